vga_sync_timing: RTL
====================

# vga_sync_timing

Consumes the divided-clock outputs of the board clock converter (the 25 MHz pixel-rate square wave and the game `update` toggle) and turns them into VGA raster timing and a frame-aligned game tick. It runs entirely on the 50 MHz board clock. It detects pixel-rate edges to advance 640x480@60 horizontal and vertical counters, drives `hsync`/`vsync`/`video_on`/pixel coordinates, and releases one `frame_tick` per `update` toggle at the start of vertical blank. Player and block logic then update tear-free.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal porch/sync widths in pixels
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical porch/sync widths in lines
- `clk` input 1: 50 MHz board clock, single clock domain
- `resetn` input 1: asynchronous, active-low reset
- `pix_clk` input 1: 25 MHz square wave generated from `clk`, synchronous to `clk`
- `update` input 1: game-rate toggle; each edge (rise or fall) is one game event
- `hsync` output 1: horizontal sync, active low
- `vsync` output 1: vertical sync, active low
- `video_on` output 1: high inside the 640x480 visible area
- `x` output 10: horizontal pixel counter, 0..799
- `y` output 10: vertical line counter, 0..524
- `pix_en` output 1: one-`clk` pulse per pixel; downstream pixel logic qualifies on it
- `frame_tick` output 1: one-`clk` pulse, the game-update strobe
- `tick_overrun` output 1: sticky; set when a pending tick is overwritten

## Operation
- **Pixel enable**
  - `pix_q` samples `pix_clk` every `clk`.
  - `pix_en = pix_clk & ~pix_q`.
  - `pix_q` resets to 1, so no spurious edge occurs at reset release.
- **Horizontal counter** `x`
  - Advances only on `pix_en`.
  - Wraps at H_TOTAL-1 = 799 to 0.
- **Vertical counter** `y`
  - Advances on `pix_en` when `x` = 799.
  - Wraps at V_TOTAL-1 = 524 to 0.
- **Sync decode**
  - `hsync` = 0 for `x` in [H_VISIBLE+H_FRONT, +H_SYNC-1] = [656, 751].
  - `vsync` = 0 for `y` in [490, 491].
  - `video_on` = (`x` < 640) && (`y` < 480).
- **Update edge detection**
  - `upd_q` samples `update`; an edge is `update ^ upd_q`.
  - Edges are ignored in the first `clk` after reset deassertion, while the `armed` flag sets.
- **Tick FSM (2 states)**
  - IDLE -> PENDING on an edge.
  - PENDING -> IDLE on the release event: the `pix_en` where counters go (799,479) -> (0,480). That cycle registers `frame_tick` = 1.
  - Edge while PENDING, with no release that cycle: stay PENDING and set `tick_overrun`.
  - Edge in the same cycle as a release: emit `frame_tick` and stay PENDING. No overrun.

## Timing
- **Reset values**
  - Counters reset to (799, 524), so the first `pix_en` yields (0,0).
  - Outputs during reset: `x`=799, `y`=524, `hsync`=1, `vsync`=1, `video_on`=0, `pix_en`=0, `frame_tick`=0, `tick_overrun`=0, state IDLE.
- **Registered outputs**
  - `hsync`, `vsync`, `video_on`, `x` and `y` are registered.
  - They are decoded from next-counter values and change together, only on the `clk` edge ending a `pix_en` cycle. They are glitch-free.
- **Pixel enable timing**
  - `pix_en` is combinational from `pix_clk`/`pix_q`.
  - It is high exactly 1 `clk` in every 2 when `pix_clk` toggles every `clk`.
- **`frame_tick` latency**
  - `frame_tick` asserts 1 `clk` after the release `pix_en`.
  - From an `update` edge to `frame_tick`: at most one frame (840 000 `clk`) plus 2 `clk`.
- **Reset mid-frame**
  - Counters, the pending tick and `tick_overrun` clear asynchronously.
  - Raster restarts at (0,0) on the first `pix_en` after release.
- **Stalled `pix_clk`**: counters hold and no `frame_tick` is emitted.

## Structure
- Shared package `vga_pkg`:
  - 640x480@60 timing constants
  - H_TOTAL = 800 and V_TOTAL = 525
  - counter width 10
  - tick-FSM state enum {IDLE, PENDING}
- Natural sub-module: `edge_detect` (sample register plus rise/any-edge output, configurable reset value), instantiated for `pix_clk` and `update`.

## Test plan
- **Reset raster start**: `pix_clk` toggling every `clk`, release `resetn`.
  - First `pix_en` gives `x`=0, `y`=0, `video_on`=1, `hsync`=1, `vsync`=1.
  - No `frame_tick`.
- **Line and frame timing**: free-run one frame.
  - `hsync` low for exactly 96 `pix_en` starting at `x`=656.
  - Line period 1600 `clk`.
  - `vsync` low for lines 490-491.
  - Frame period 840 000 `clk`.
  - `video_on` high for 307 200 `pix_en` per frame.
- **Tick release**: toggle `update` at `y`=100.
  - Exactly one `frame_tick`, 1 `clk` after the (799,479)->(0,480) `pix_en`.
  - None elsewhere in the frame.
- **Overrun**: toggle `update` at `y`=10, and again at `y`=200 (both edges before the release at the vertical-blank boundary).
  - One `frame_tick` at the release.
  - `tick_overrun`=1 and stays set until reset.
- **Simultaneous edge and release**: toggle `update` in the same `clk` as the release.
  - `frame_tick` that frame, and another `frame_tick` the next frame.
  - `tick_overrun` stays 0.
- **Reset mid-operation**: assert `resetn` low at (300,250) with a tick pending.
  - Outputs go to reset values immediately.
  - After release, no `frame_tick` until a new `update` edge.
  - `update`=1 held through reset produces no spurious tick.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster constants and tick FSM state type.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W     = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } tick_state_t;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - sample register with rising-edge or any-edge strobe.
module edge_detect #(
  parameter logic RESET_VAL = 1'b0,
  parameter bit   ANY_EDGE  = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_sig,
  output logic o_edge
);

  logic r_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_q <= RESET_VAL;
    else         r_q <= i_sig;
  end

  assign o_edge = ANY_EDGE ? (i_sig ^ r_q) : (i_sig & ~r_q);

endmodule

// File: rtl/vga_sync_timing.sv
// rtl/vga_sync_timing.sv - VGA raster counters/syncs on the board clock,
// plus a game tick released at the start of vertical blank.
module vga_sync_timing #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      pix_clk,
  input  logic                      update,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      video_on,
  output logic [vga_pkg::CNT_W-1:0] x,
  output logic [vga_pkg::CNT_W-1:0] y,
  output logic                      pix_en,
  output logic                      frame_tick,
  output logic                      tick_overrun
);
  import vga_pkg::*;

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] Y_REL    = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             w_pix_en, w_upd_any, w_upd_edge, w_release;
  logic             r_armed, r_hsync, r_vsync, r_video_on, r_frame_tick, r_overrun;
  logic [CNT_W-1:0] r_x, r_y, w_x_next, w_y_next;
  tick_state_t      r_state, w_state_next;
  logic             w_tick_next, w_ovr_set;

  // Sample register resets high so reset release never looks like a pixel edge.
  edge_detect #(.RESET_VAL(1'b1), .ANY_EDGE(1'b0)) u_pix_edge (
    .clk(clk), .resetn(resetn), .i_sig(pix_clk), .o_edge(w_pix_en)
  );

  edge_detect #(.RESET_VAL(1'b0), .ANY_EDGE(1'b1)) u_upd_edge (
    .clk(clk), .resetn(resetn), .i_sig(update), .o_edge(w_upd_any)
  );

  assign w_upd_edge = w_upd_any & r_armed;
  assign w_release  = w_pix_en && (r_x == X_LAST) && (r_y == Y_REL);

  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_pix_en) begin
      if (r_x == X_LAST) begin
        w_x_next = '0;
        w_y_next = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        w_x_next = r_x + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = 1'b0;
    w_ovr_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_upd_edge) w_state_next = PENDING;
      end
      PENDING: begin
        if (w_release) begin
          w_tick_next  = 1'b1;
          w_state_next = w_upd_edge ? PENDING : IDLE;
        end else if (w_upd_edge) begin
          w_ovr_set = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Decoding from next-counter values keeps syncs aligned with x/y.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x          <= X_LAST;
      r_y          <= Y_LAST;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_video_on   <= 1'b0;
      r_armed      <= 1'b0;
      r_state      <= IDLE;
      r_frame_tick <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_hsync      <= !((w_x_next >= HS_START) && (w_x_next < HS_END));
      r_vsync      <= !((w_y_next >= VS_START) && (w_y_next < VS_END));
      r_video_on   <= (w_x_next < X_VIS) && (w_y_next < Y_VIS);
      r_armed      <= 1'b1;
      r_state      <= w_state_next;
      r_frame_tick <= w_tick_next;
      r_overrun    <= r_overrun | w_ovr_set;
    end
  end

  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign video_on     = r_video_on;
  assign x            = r_x;
  assign y            = r_y;
  assign pix_en       = w_pix_en;
  assign frame_tick   = r_frame_tick;
  assign tick_overrun = r_overrun;

endmodule
